sha256_engine_mp: RTL and testbench

SHA256_ENGINE_MP -- requirements
Module: sha256_engine_mp

---
 rtl/sha256_engine_mp.sv | 160 ++++++++++++++++
 tb/tb_sha256_engine_mp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_engine_mp.sv
// SHA-256/224 compression engine with a bus-written 16-word message buffer,
// a rolling 16-word schedule window and UNROLL rounds per clock.
module sha256_engine_mp #(
  parameter int UNROLL    = 1,
  parameter bit SHA224_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         chipselect,
  input  logic         write,
  input  logic [3:0]   address,
  input  logic [31:0]  writedata,
  input  logic         start,
  input  logic         init,
  input  logic         mode224,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  localparam logic [5:0] STEP = 6'(UNROLL);
  localparam logic [5:0] LAST = 6'(64 - UNROLL);

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [1:0]   r_state;
  logic [5:0]   r_cnt;
  logic         r_done;
  logic [31:0]  r_msg [0:15];
  logic [31:0]  r_w   [0:15];
  logic [31:0]  r_v   [0:7];
  logic [31:0]  r_h   [0:7];
  logic [31:0]  w_w_nxt [0:15];
  logic [31:0]  w_v_nxt [0:7];
  logic [255:0] w_iv;

  assign w_iv      = (SHA224_EN && mode224) ? IV224 : IV256;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

  always_comb begin
    for (int i = 0; i < 8; i++) digest[255 - 32*i -: 32] = r_h[i];
  end

  // Window holds W[cnt..cnt+15]; extend by UNROLL words and slide forward.
  always_comb begin : sched
    logic [31:0] ext [0:15+UNROLL];
    for (int i = 0; i < 16; i++) ext[i] = r_w[i];
    for (int k = 0; k < UNROLL; k++)
      ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
    for (int i = 0; i < 16; i++) w_w_nxt[i] = ext[i+UNROLL];
  end

  always_comb begin : rounds
    logic [31:0] v [0:7];
    logic [31:0] t1;
    logic [31:0] t2;
    logic [5:0]  t;
    for (int i = 0; i < 8; i++) v[i] = r_v[i];
    t1 = '0;
    t2 = '0;
    t  = '0;
    for (int j = 0; j < UNROLL; j++) begin
      t  = r_cnt + 6'(j);
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + r_w[j];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) w_v_nxt[i] = v[i];
  end

  // Buffer is not reset; reset only blocks writes in its own cycle.
  always_ff @(posedge clk) begin
    if (!reset && chipselect && write) r_msg[address] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < 8; i++) r_h[i] <= IV256[255 - 32*i -: 32];
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_ROUND;
          r_cnt   <= '0;
          for (int i = 0; i < 16; i++) r_w[i] <= r_msg[i];
          for (int i = 0; i < 8; i++) begin
            if (init) begin
              r_h[i] <= w_iv[255 - 32*i -: 32];
              r_v[i] <= w_iv[255 - 32*i -: 32];
            end else begin
              r_v[i] <= r_h[i];
            end
          end
        end
        S_ROUND: begin
          for (int i = 0; i < 8; i++) r_v[i] <= w_v_nxt[i];
          for (int i = 0; i < 16; i++) r_w[i] <= w_w_nxt[i];
          if (r_cnt == LAST) begin
            r_state <= S_FINAL;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + STEP;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_engine_mp.sv
// Directed bench for sha256_engine_mp: known-answer digests, latency,
// busy/done behaviour, ignored start, back-to-back chaining and abort by reset.
module tb_sha256_engine_mp;

  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [223:0] ABC224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] EMPTY256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] writedata = '0;
  logic        start = 1'b0;
  logic        init = 1'b0;
  logic        mode224 = 1'b0;

  logic         busy [0:3];
  logic         done [0:3];
  logic [255:0] digest [0:3];
  logic [1:0]   dbg_state [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_engine_mp #(.UNROLL(1), .SHA224_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .start(start), .init(init), .mode224(mode224),
    .busy(busy[0]), .done(done[0]), .digest(digest[0]), .dbg_state(dbg_state[0]));
  sha256_engine_mp #(.UNROLL(2), .SHA224_EN(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .start(start), .init(init), .mode224(mode224),
    .busy(busy[1]), .done(done[1]), .digest(digest[1]), .dbg_state(dbg_state[1]));
  sha256_engine_mp #(.UNROLL(4), .SHA224_EN(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .start(start), .init(init), .mode224(mode224),
    .busy(busy[2]), .done(done[2]), .digest(digest[2]), .dbg_state(dbg_state[2]));
  sha256_engine_mp #(.UNROLL(8), .SHA224_EN(1'b1)) u_dut8 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .start(start), .init(init), .mode224(mode224),
    .busy(busy[3]), .done(done[3]), .digest(digest[3]), .dbg_state(dbg_state[3]));

  // All driver tasks are entered just after a falling edge.
  task automatic write_block(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) begin
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 4'(i);
      writedata  = blk[511 - 32*i -: 32];
      @(negedge clk);
    end
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic start_now(input logic i_init, input logic i_m224);
    start   = 1'b1;
    init    = i_init;
    mode224 = i_m224;
    @(negedge clk);
    start   = 1'b0;
    init    = 1'b0;
    mode224 = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen on dut1.
  task automatic wait_done(input int n0, output int lat);
    int n;
    n = n0;
    while (!done[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy[0]); end
    checks++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done[0]); end
    checks++;
    if (digest[0] !== IV256) begin errors++; $display("FAIL reset_digest got %h exp %h", digest[0], IV256); end
    checks++;
    if (dbg_state[0] !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state[0]); end
  endtask

  task automatic test_abc;
    int lat;
    write_block(BLK_ABC);
    @(negedge clk);
    start_now(1'b1, 1'b0);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL abc_busy got %b exp 1", busy[0]); end
    wait_done(0, lat);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL abc_latency got %0d exp 65", lat); end
    checks++;
    if (digest[0] !== ABC256) begin errors++; $display("FAIL abc_digest got %h exp %h", digest[0], ABC256); end
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL abc_busy_at_done got %b exp 0", busy[0]); end
    @(negedge clk);
    checks++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL abc_done_width got %b exp 0", done[0]); end
    checks++;
    if (digest[0] !== ABC256) begin errors++; $display("FAIL abc_digest_hold got %h exp %h", digest[0], ABC256); end
  endtask

  task automatic test_sha224;
    int lat;
    start_now(1'b1, 1'b1);
    wait_done(0, lat);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL sha224_latency got %0d exp 65", lat); end
    checks++;
    if (digest[0][255:32] !== ABC224)
      begin errors++; $display("FAIL sha224_digest got %h exp %h", digest[0][255:32], ABC224); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    start_now(1'b1, 1'b0);
    repeat (9) @(negedge clk);
    start_now(1'b1, 1'b1);
    wait_done(10, lat);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL ignore_latency got %0d exp 65", lat); end
    checks++;
    if (digest[0] !== ABC256) begin errors++; $display("FAIL ignore_digest got %h exp %h", digest[0], ABC256); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    write_block(BLK_TWO1);
    start_now(1'b1, 1'b0);
    write_block(BLK_TWO2);
    wait_done(16, lat);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL b2b_first_latency got %0d exp 65", lat); end
    start_now(1'b0, 1'b0);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b exp 1", busy[0]); end
    wait_done(0, lat);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL b2b_second_latency got %0d exp 65", lat); end
    checks++;
    if (digest[0] !== TWO256) begin errors++; $display("FAIL b2b_digest got %h exp %h", digest[0], TWO256); end
    @(negedge clk);
  endtask

  task automatic test_unroll;
    int lat [0:3];
    int exp_lat;
    for (int k = 0; k < 4; k++) lat[k] = -1;
    write_block(BLK_EMPTY);
    @(negedge clk);
    start_now(1'b1, 1'b0);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (done[k] === 1'b1 && lat[k] < 0) lat[k] = n;
    end
    for (int k = 0; k < 4; k++) begin
      exp_lat = (64 >> k) + 1;
      checks++;
      if (lat[k] !== exp_lat)
        begin errors++; $display("FAIL unroll%0d_latency got %0d exp %0d", 1 << k, lat[k], exp_lat); end
      checks++;
      if (digest[k] !== EMPTY256)
        begin errors++; $display("FAIL unroll%0d_digest got %h exp %h", 1 << k, digest[k], EMPTY256); end
    end
  endtask

  task automatic test_abort;
    int seen;
    write_block(BLK_ABC);
    start_now(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy[0]); end
    checks++;
    if (dbg_state[0] !== 2'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", dbg_state[0]); end
    checks++;
    if (digest[0] !== IV256) begin errors++; $display("FAIL abort_digest got %h exp %h", digest[0], IV256); end
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      if (done[0] === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", seen); end
    checks++;
    if (digest[0] !== IV256) begin errors++; $display("FAIL abort_digest_hold got %h exp %h", digest[0], IV256); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_abc;
    test_sha224;
    test_ignore_start;
    test_back_to_back;
    test_unroll;
    test_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
